ingress_buffer: RTL and testbench
=================================

Name: ingress_buffer

Overview:
- Receive-side counterpart of the switch egress stage: accepts packet beats from a port link and buffers them in a small FIFO before the switch core reads them.
- Validates sop/eop framing on the input side; discards orphan beats and counts framing errors.
- Sits between the port receive logic (upstream) and the switch arbitration/crossbar (downstream).
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 128, data beat width in bits.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  buffer can accept a beat
- in_data  input  WIDTH  upstream beat data
- in_sop  input  1  beat is first of packet
- in_eop  input  1  beat is last of packet
- out_valid  output  1  head entry available
- out_ready  input  1  downstream consumes head
- out_data  output  WIDTH  head entry data
- out_sop  output  1  head entry sop flag
- out_eop  output  1  head entry eop flag
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- err_count  output  CNT_W  framing error count, saturating

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values while reset_n is low:
  - Read/write pointers and level are 0; out_valid is 0.
  - out_data, out_sop and out_eop are 0; err_count is 0.
  - in_ready is forced to 0; FSM is IDLE.
- Reset mid-packet discards all stored entries and any partial packet. The first beat after reset must carry sop.
- Input accept: in_ready = !full. A beat is accepted when in_valid && in_ready. Upstream holds data and flags stable until accepted.
- Framing FSM acts on accepted beats only. States are IDLE and IN_PKT.
  - IDLE, beat with sop: written to the FIFO. If eop is also set (single-beat packet), stay in IDLE; otherwise go to IN_PKT.
  - IDLE, beat without sop: consumed (handshake completes) but not written. err_count increments.
  - IN_PKT, beat without sop: written. If eop is set, go to IDLE.
  - IN_PKT, beat with sop: treated as the start of a new packet and written. err_count increments (previous packet truncated). Next state follows eop, as in IDLE.
- Each entry stores {sop, eop, data}.
- Output is first-word fall-through: out_valid = !empty, and out_* present the head entry combinationally from storage. A pop occurs on out_valid && out_ready.
- Latency: a beat accepted at edge N is visible at the output after edge N, i.e. out_valid is high in cycle N+1. There is no same-cycle bypass when empty.
- Simultaneous push and pop (not full, not empty): both occur and level is unchanged.
- When full, in_ready is 0; a pop in that cycle frees space, and in_ready rises the next cycle (no combinational ready-through).
- When empty, out_ready is ignored and out_* hold their last value, which is don't-care.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from level.
- err_count saturates at 2^CNT_W - 1 and never wraps.
- Discarded beats never affect level or the FIFO pointers.

Decomposition:
- Package switch_pkg holds:
  - typedef enum ingress_state_e {IDLE, IN_PKT};
  - the beat struct (sop, eop, data) parameterised by WIDTH via a localparam default;
  - shared constant DEF_WIDTH = 128.
- Sub-module: ingress_fifo_mem, a simple dual-index register array (DEPTH x (WIDTH+2)) with write port and asynchronous read. Pointer and level control stays in ingress_buffer.

Test Plan:
- Reset then single-beat packet: in_data=0xA5, sop=1, eop=1, out_ready=0 → next cycle out_valid=1, out_data=0xA5, out_sop=out_eop=1, level=1; pulse out_ready → level=0, out_valid=0.
- Fill to full: 8 beats of a packet (sop on beat 0, eop on beat 7), out_ready=0 → level=8, in_ready=0 after the 8th accept; a 9th beat is held by upstream and not lost; one pop → in_ready=1 next cycle and the 9th beat is accepted.
- Orphan beat: in IDLE, beat 0x11 with sop=0 → handshake completes, level stays 0, err_count=1, nothing appears at the output.
- Truncated packet: sop beat 0x1, middle beat 0x2, then sop beat 0x3 with eop → all three stored in order, err_count=1, FSM ends in IDLE.
- Streaming with out_ready=1 continuously: 20 back-to-back beats → one beat out per cycle after 1-cycle latency, level ≤ 1, pointers wrap past 7 with correct data order.
- Async reset mid-packet: assert reset_n low with level=5 between clock edges → level=0, out_valid=0, in_ready=0 immediately; after release, err_count=0 and a non-sop beat increments err_count to 1.

Source files
------------

// File: rtl/switch_pkg.sv
// Types and constants shared by the switch ingress/egress datapath.
package switch_pkg;

  localparam int unsigned DEF_WIDTH  = 128;
  localparam int unsigned BEAT_WIDTH = DEF_WIDTH;

  typedef enum logic {
    IDLE,
    IN_PKT
  } ingress_state_e;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [BEAT_WIDTH-1:0] data;
  } ingress_beat_t;

endpackage

// File: rtl/ingress_fifo_mem.sv
// Register-array storage for the ingress FIFO: one write port, one async read port.
module ingress_fifo_mem #(
  parameter int unsigned WIDTH = 130,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Cleared on reset so the head outputs read as zero while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ingress_buffer.sv
// Ingress FIFO with sop/eop framing check; orphan beats are dropped and counted.
module ingress_buffer
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = WIDTH + 2;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  ingress_state_e r_state, w_state_d;
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_level;
  logic [CNT_W-1:0] r_err_count;
  logic           w_full, w_empty, w_accept, w_write, w_err, w_pop;
  logic [EW-1:0]  w_rd_data;

  assign w_full   = (r_level == FULL_LEVEL);
  assign w_empty  = (r_level == '0);
  // Gate with reset so upstream sees not-ready the moment reset asserts.
  assign in_ready = reset_n && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_pop    = !w_empty && out_ready;

  always_comb begin
    w_state_d = r_state;
    w_write   = 1'b0;
    w_err     = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          w_write = in_sop;
          w_err   = !in_sop;
        end
        IN_PKT: begin
          w_write = 1'b1;
          w_err   = in_sop;
        end
        default: begin
          w_write = 1'b0;
          w_err   = 1'b0;
        end
      endcase
      if (w_write) begin
        w_state_d = in_eop ? IDLE : IN_PKT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_err_count <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_write && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_write && w_pop) begin
        r_level <= r_level - 1'b1;
      end
      if (w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  ingress_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_write),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({in_sop, in_eop, in_data}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign out_valid = !w_empty;
  assign out_sop   = w_rd_data[WIDTH+1];
  assign out_eop   = w_rd_data[WIDTH];
  assign out_data  = w_rd_data[WIDTH-1:0];
  assign level     = r_level;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ingress_buffer.sv
// Scoreboard bench for ingress_buffer: framing, fill/backpressure, streaming, async reset.
module tb_ingress_buffer;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int unsigned EW    = WIDTH + 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_sop;
  logic             out_eop;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] err_count;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] sb[$];

  always #5 clk = ~clk;

  ingress_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .level     (level),
    .err_count (err_count)
  );

  // Scoreboard: every pop is compared against the oldest stored beat.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got sop=%0b eop=%0b data=%h, expected no output",
                 out_sop, out_eop, out_data);
      end else begin
        logic [EW-1:0] exp;
        exp = sb.pop_front();
        if ({out_sop, out_eop, out_data} !== exp) begin
          failures++;
          $display("FAIL pop_data: got %h, expected %h", {out_sop, out_eop, out_data}, exp);
        end
      end
    end
  end

  // Present a beat and hold it until accepted; pushes to the scoreboard if it should be stored.
  task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic e,
                      input logic store);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    acc      = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected accept");
    end else if (store) begin
      sb.push_back({s, e, d});
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (level == '0) begin
        done = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (!done || sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got level=%0d pending=%0d, expected 0 and 0", level, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({level, out_valid, in_ready, out_sop, out_eop} !== {LW'(0), 4'b0000}) begin
      failures++;
      $display("FAIL reset_ctrl: got level=%0d ov=%0b ir=%0b sop=%0b eop=%0b, expected all 0",
               level, out_valid, in_ready, out_sop, out_eop);
    end
    checks++;
    if (out_data !== '0 || err_count !== '0) begin
      failures++;
      $display("FAIL reset_data: got data=%h err=%0d, expected 0 and 0", out_data, err_count);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #10;
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    send(128'hA5, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({out_valid, out_sop, out_eop, level} !== {3'b111, LW'(1)} || out_data !== 128'hA5) begin
      failures++;
      $display("FAIL single_head: got ov=%0b sop=%0b eop=%0b lvl=%0d data=%h, expected 1 1 1 1 a5",
               out_valid, out_sop, out_eop, level, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (level !== LW'(0) || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: got lvl=%0d ov=%0b, expected 0 0", level, out_valid);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(WIDTH'(32'h100 + i), (i == 0), (i == 7), 1'b1);
    end
    checks++;
    if (level !== LW'(8) || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: got lvl=%0d ir=%0b, expected 8 0", level, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 128'h200;
    in_sop   = 1'b1;
    in_eop   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (level !== LW'(8) || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_hold: got lvl=%0d ir=%0b, expected 8 0", level, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (level !== LW'(7) || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_free: got lvl=%0d ir=%0b, expected 7 1", level, in_ready);
    end
    send(128'h200, 1'b1, 1'b1, 1'b1);
    checks++;
    if (level !== LW'(8) || err_count !== '0) begin
      failures++;
      $display("FAIL fill_ninth: got lvl=%0d err=%0d, expected 8 0", level, err_count);
    end
    drain();
  endtask

  task automatic test_orphan();
    out_ready = 1'b0;
    send(128'h11, 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== LW'(0) || out_valid !== 1'b0 || err_count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL orphan: got lvl=%0d ov=%0b err=%0d, expected 0 0 1",
               level, out_valid, err_count);
    end
  endtask

  task automatic test_truncated();
    out_ready = 1'b0;
    send(128'h1, 1'b1, 1'b0, 1'b1);
    send(128'h2, 1'b0, 1'b0, 1'b1);
    send(128'h3, 1'b1, 1'b1, 1'b1);
    checks++;
    if (level !== LW'(3) || err_count !== CNT_W'(2)) begin
      failures++;
      $display("FAIL trunc_store: got lvl=%0d err=%0d, expected 3 2", level, err_count);
    end
    // Non-sop beat is an orphan only if the FSM returned to IDLE.
    send(128'h44, 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== LW'(3) || err_count !== CNT_W'(3)) begin
      failures++;
      $display("FAIL trunc_idle: got lvl=%0d err=%0d, expected 3 3", level, err_count);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(WIDTH'(32'hC00 + i), (i == 0), (i == 19), 1'b1);
      checks++;
      if (level > LW'(1) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stream_level: got lvl=%0d ov=%0b at beat %0d, expected <=1 and 1",
                 level, out_valid, i);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (level !== LW'(0) || sb.size() != 0) begin
      failures++;
      $display("FAIL stream_end: got lvl=%0d pending=%0d, expected 0 0", level, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(WIDTH'(32'hD00 + i), (i == 0), 1'b0, 1'b1);
    end
    checks++;
    if (level !== LW'(5)) begin
      failures++;
      $display("FAIL mid_level: got lvl=%0d, expected 5", level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (level !== LW'(0) || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: got lvl=%0d ov=%0b ir=%0b, expected 0 0 0",
               level, out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checks++;
    if (err_count !== '0) begin
      failures++;
      $display("FAIL mid_err_clr: got err=%0d, expected 0", err_count);
    end
    send(128'h55, 1'b0, 1'b0, 1'b0);
    checks++;
    if (err_count !== CNT_W'(1) || level !== LW'(0)) begin
      failures++;
      $display("FAIL mid_orphan: got err=%0d lvl=%0d, expected 1 0", err_count, level);
    end
    send(128'h66, 1'b1, 1'b1, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_orphan();
    test_truncated();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
